// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_pkg
// Brief    : Shared types and helpers for the multiplier operand issuer.
// Revision : 1.0
// ============================================================================
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RES = 2'd2,
    RESP     = 2'd3
  } issuer_state_t;

  typedef logic signed [15:0] operand_t;
  typedef logic signed [31:0] product_t;

  // Reduction XOR; operands are zero-extended into the 32-bit argument.
  function automatic logic parity_f(input logic [31:0] v);
    return ^v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_op_issuer_if.sv
`default_nettype none
// ============================================================================
// Module   : mult_op_issuer_if
// Brief    : Operand stream, multiplier handshake, response stream, counters.
// Revision : 1.0
// ============================================================================
interface mult_op_issuer_if
  import mult_pkg::*;
#(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  operand_t         in_a;
  operand_t         in_b;
  logic             in_inj_a;
  logic             in_inj_b;

  logic             req;
  operand_t         arg_a;
  logic             arg_a_parity;
  operand_t         arg_b;
  logic             arg_b_parity;
  logic             ack;
  product_t         result;
  logic             result_parity;
  logic             arg_parity_error;
  logic             result_rdy;

  logic             out_valid;
  logic             out_ready;
  product_t         out_result;
  logic             out_res_par_ok;
  logic             out_arg_err;
  logic             out_timeout;

  logic [CNT_W-1:0] cnt_ops;
  logic [CNT_W-1:0] cnt_arg_err;
  logic [CNT_W-1:0] cnt_par_err;
  logic [CNT_W-1:0] cnt_timeout;

  modport master (
    input  in_valid, in_a, in_b, in_inj_a, in_inj_b,
    input  ack, result, result_parity, arg_parity_error, result_rdy,
    input  out_ready,
    output in_ready, req, arg_a, arg_a_parity, arg_b, arg_b_parity,
    output out_valid, out_result, out_res_par_ok, out_arg_err, out_timeout,
    output cnt_ops, cnt_arg_err, cnt_par_err, cnt_timeout
  );

  modport slave (
    output in_valid, in_a, in_b, in_inj_a, in_inj_b,
    output ack, result, result_parity, arg_parity_error, result_rdy,
    output out_ready,
    input  in_ready, req, arg_a, arg_a_parity, arg_b, arg_b_parity,
    input  out_valid, out_result, out_res_par_ok, out_arg_err, out_timeout,
    input  cnt_ops, cnt_arg_err, cnt_par_err, cnt_timeout
  );
endinterface
`default_nettype wire

// File: rtl/mult_op_issuer_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Event counter that sticks at all-ones instead of wrapping.
// Revision : 1.0
// ============================================================================
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             inc_i,
  output logic      [CNT_W-1:0] value_o
);

  logic [CNT_W-1:0] value_q;
  logic [CNT_W-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (inc_i && (value_q != {CNT_W{1'b1}})) begin
      value_d = value_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule
`default_nettype wire

// File: rtl/mult_op_issuer.sv
`default_nettype none
// ============================================================================
// Module   : mult_op_issuer
// Brief    : Drives the 16x16 multiplier handshake from an operand stream and
//            returns parity-checked results with status and event counters.
// Revision : 1.0
// ============================================================================
module mult_op_issuer
  import mult_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 16
) (
  input wire logic         clk,
  input wire logic         rst,
  mult_op_issuer_if.master bus
);

  localparam int            TW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

  issuer_state_t state_q, state_d;
  logic          req_q, req_d;
  operand_t      arg_a_q, arg_a_d;
  operand_t      arg_b_q, arg_b_d;
  logic          apar_q, apar_d;
  logic          bpar_q, bpar_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          out_valid_q, out_valid_d;
  product_t      out_result_q, out_result_d;
  logic          par_ok_q, par_ok_d;
  logic          arg_err_q, arg_err_d;
  logic          timeout_q, timeout_d;

  logic          do_capture;
  logic          do_expire;
  logic          resp_done;

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    arg_a_d      = arg_a_q;
    arg_b_d      = arg_b_q;
    apar_d       = apar_q;
    bpar_d       = bpar_q;
    timer_d      = timer_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    par_ok_d     = par_ok_q;
    arg_err_d    = arg_err_q;
    timeout_d    = timeout_q;
    do_capture   = 1'b0;
    do_expire    = 1'b0;
    resp_done    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          arg_a_d = bus.in_a;
          arg_b_d = bus.in_b;
          apar_d  = parity_f({16'h0000, bus.in_a}) ^ bus.in_inj_a;
          bpar_d  = parity_f({16'h0000, bus.in_b}) ^ bus.in_inj_b;
          req_d   = 1'b1;
          timer_d = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        // ack wins over expiry on the final waiting cycle
        if (bus.ack) begin
          req_d   = 1'b0;
          timer_d = '0;
          if (bus.result_rdy) begin
            do_capture = 1'b1;
          end else begin
            state_d = WAIT_RES;
          end
        end else if (timer_q == TMAX) begin
          do_expire = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      WAIT_RES: begin
        if (bus.result_rdy) begin
          do_capture = 1'b1;
        end else if (timer_q == TMAX) begin
          do_expire = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      RESP: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          resp_done   = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_capture) begin
      out_result_d = bus.result;
      par_ok_d     = (bus.result_parity == parity_f(bus.result));
      arg_err_d    = bus.arg_parity_error;
      timeout_d    = 1'b0;
      out_valid_d  = 1'b1;
      state_d      = RESP;
    end

    // Status flags are cleared on timeout so only cnt_timeout counts it
    if (do_expire) begin
      req_d        = 1'b0;
      out_result_d = '0;
      par_ok_d     = 1'b0;
      arg_err_d    = 1'b0;
      timeout_d    = 1'b1;
      out_valid_d  = 1'b1;
      state_d      = RESP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      arg_a_q      <= '0;
      arg_b_q      <= '0;
      apar_q       <= 1'b0;
      bpar_q       <= 1'b0;
      timer_q      <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      par_ok_q     <= 1'b0;
      arg_err_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      arg_a_q      <= arg_a_d;
      arg_b_q      <= arg_b_d;
      apar_q       <= apar_d;
      bpar_q       <= bpar_d;
      timer_q      <= timer_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      par_ok_q     <= par_ok_d;
      arg_err_q    <= arg_err_d;
      timeout_q    <= timeout_d;
    end
  end

  assign bus.in_ready       = (state_q == IDLE);
  assign bus.req            = req_q;
  assign bus.arg_a          = arg_a_q;
  assign bus.arg_b          = arg_b_q;
  assign bus.arg_a_parity   = apar_q;
  assign bus.arg_b_parity   = bpar_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_result     = out_result_q;
  assign bus.out_res_par_ok = par_ok_q;
  assign bus.out_arg_err    = arg_err_q;
  assign bus.out_timeout    = timeout_q;

  sat_counter #(.CNT_W(CNT_W)) u_cnt_ops (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (resp_done),
    .value_o (bus.cnt_ops)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_arg_err (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (resp_done & arg_err_q),
    .value_o (bus.cnt_arg_err)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_par_err (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (resp_done & ~par_ok_q & ~timeout_q),
    .value_o (bus.cnt_par_err)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_timeout (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (resp_done & timeout_q),
    .value_o (bus.cnt_timeout)
  );

endmodule
`default_nettype wire

// File: tb/tb_mult_op_issuer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_op_issuer
// Brief    : Directed vector table plus timeout, backpressure and reset cases.
// Revision : 1.0
// ============================================================================
module tb_mult_op_issuer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mult_op_issuer_if #(.CNT_W(16)) bus ();

  mult_op_issuer #(.TIMEOUT_CYC(8), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        inj_a;
    logic        inj_b;
    logic        mul_err;
    logic        flip_par;
    int          ack_dly;
    int          res_dly;
    logic        exp_apar;
    logic        exp_bpar;
    logic [31:0] exp_res;
    logic        exp_ok;
    logic        exp_err;
  } vec_t;

  vec_t vecs[5];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   e_ops = 0, e_arg = 0, e_par = 0, e_to = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic ia, input logic ib);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_inj_a = ia;
    bus.in_inj_b = ib;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic drive_res(input logic [31:0] r, input logic flip, input logic err);
    bus.result           = r;
    bus.result_parity    = (^r) ^ flip;
    bus.arg_parity_error = err;
    bus.result_rdy       = 1'b1;
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_cnt_ops"},     {16'h0, bus.cnt_ops},     e_ops);
    chk({tag, "_cnt_arg_err"}, {16'h0, bus.cnt_arg_err}, e_arg);
    chk({tag, "_cnt_par_err"}, {16'h0, bus.cnt_par_err}, e_par);
    chk({tag, "_cnt_timeout"}, {16'h0, bus.cnt_timeout}, e_to);
  endtask

  task automatic accept_resp();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    chk("in_ready_idle", {31'h0, bus.in_ready}, 1);
    issue(v.a, v.b, v.inj_a, v.inj_b);
    chk("req_up",   {31'h0, bus.req}, 1);
    chk("arg_a",    {16'h0, bus.arg_a}, {16'h0, v.a});
    chk("arg_b",    {16'h0, bus.arg_b}, {16'h0, v.b});
    chk("arg_apar", {31'h0, bus.arg_a_parity}, {31'h0, v.exp_apar});
    chk("arg_bpar", {31'h0, bus.arg_b_parity}, {31'h0, v.exp_bpar});
    repeat (v.ack_dly) tick();
    chk("req_before_ack", {31'h0, bus.req}, 1);
    bus.ack = 1'b1;
    if (v.res_dly == 0) drive_res(v.exp_res, v.flip_par, v.mul_err);
    tick();
    bus.ack        = 1'b0;
    bus.result_rdy = 1'b0;
    if (v.res_dly > 0) begin
      chk("req_after_ack", {31'h0, bus.req}, 0);
      chk("no_early_valid", {31'h0, bus.out_valid}, 0);
      repeat (v.res_dly - 1) tick();
      drive_res(v.exp_res, v.flip_par, v.mul_err);
      tick();
      bus.result_rdy = 1'b0;
    end
    chk("out_valid",   {31'h0, bus.out_valid}, 1);
    chk("out_result",  bus.out_result, v.exp_res);
    chk("out_par_ok",  {31'h0, bus.out_res_par_ok}, {31'h0, v.exp_ok});
    chk("out_arg_err", {31'h0, bus.out_arg_err}, {31'h0, v.exp_err});
    chk("out_timeout", {31'h0, bus.out_timeout}, 0);
    e_ops++;
    if (v.exp_err) e_arg++;
    if (!v.exp_ok) e_par++;
    accept_resp();
    chk("valid_drop", {31'h0, bus.out_valid}, 0);
    chk("ready_back", {31'h0, bus.in_ready}, 1);
    check_counts("vec");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected stopped");
    $fatal(1);
  end

  initial begin
    int n;
    //         a         b         ia   ib   err  flip ack res apar bpar result          ok   err
    vecs[0] = '{16'h0003, 16'hFFFC, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1, 1'b0, 1'b0, 32'hFFFF_FFF4, 1'b1, 1'b0};
    vecs[1] = '{16'h0001, 16'h0002, 1'b1, 1'b0, 1'b1, 1'b0, 2, 3, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b1};
    vecs[2] = '{16'h0005, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b1, 32'h0000_0023, 1'b0, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1, 1'b1, 1'b0, 32'hC000_8000, 1'b1, 1'b0};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 7, 8, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0};

    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0;
    bus.in_inj_a = 1'b0; bus.in_inj_b = 1'b0;
    bus.ack = 1'b0; bus.result = '0; bus.result_parity = 1'b0;
    bus.arg_parity_error = 1'b0; bus.result_rdy = 1'b0; bus.out_ready = 1'b0;

    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_req",        {31'h0, bus.req}, 0);
    chk("rst_out_valid",  {31'h0, bus.out_valid}, 0);
    chk("rst_in_ready",   {31'h0, bus.in_ready}, 1);
    chk("rst_out_result", bus.out_result, 0);
    chk("rst_arg_a",      {16'h0, bus.arg_a}, 0);
    check_counts("rst");

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Ack never arrives: req must stay up exactly TIMEOUT_CYC cycles
    issue(16'h1234, 16'h0005, 1'b0, 1'b0);
    n = 0;
    while (bus.req && n < 20) begin
      n++;
      tick();
    end
    chk("to_req_cycles", n, 8);
    chk("to_out_valid",  {31'h0, bus.out_valid}, 1);
    chk("to_flag",       {31'h0, bus.out_timeout}, 1);
    chk("to_result",     bus.out_result, 0);
    e_ops++; e_to++;
    accept_resp();
    check_counts("to");

    // Backpressure: response held, new pair blocked until accepted
    issue(16'h0002, 16'h0003, 1'b0, 1'b0);
    bus.ack = 1'b1;
    drive_res(32'h0000_0006, 1'b0, 1'b0);
    tick();
    bus.ack = 1'b0; bus.result_rdy = 1'b0;
    bus.in_a = 16'h0010; bus.in_b = 16'h0020; bus.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid",    {31'h0, bus.out_valid}, 1);
      chk("bp_result",   bus.out_result, 32'h6);
      chk("bp_in_ready", {31'h0, bus.in_ready}, 0);
      chk("bp_no_req",   {31'h0, bus.req}, 0);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    e_ops++;
    chk("bp_idle_ready", {31'h0, bus.in_ready}, 1);
    chk("bp_idle_noreq", {31'h0, bus.req}, 0);
    tick();
    bus.in_valid = 1'b0;
    chk("bp_second_req", {31'h0, bus.req}, 1);
    chk("bp_second_a",   {16'h0, bus.arg_a}, 32'h10);
    bus.ack = 1'b1;
    drive_res(32'h0000_0200, 1'b0, 1'b0);
    tick();
    bus.ack = 1'b0; bus.result_rdy = 1'b0;
    chk("bp_second_res", bus.out_result, 32'h200);
    accept_resp();
    e_ops++;
    check_counts("bp");

    // Reset while waiting for the result
    issue(16'h0003, 16'h0003, 1'b0, 1'b0);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_req",        {31'h0, bus.req}, 0);
    chk("mr_out_valid",  {31'h0, bus.out_valid}, 0);
    chk("mr_in_ready",   {31'h0, bus.in_ready}, 1);
    chk("mr_out_result", bus.out_result, 0);
    e_ops = 0; e_arg = 0; e_par = 0; e_to = 0;
    check_counts("mr");
    tick();
    chk("mr_no_resp", {31'h0, bus.out_valid}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mult_op_issuer.md
Name: mult_op_issuer

Overview:
- Master-side protocol adapter that sits directly upstream of the 16x16 signed multiplier.
- Accepts operand pairs on a valid/ready stream and generates argument parity, with optional per-operand parity-error injection.
- Runs the multiplier req/ack/result_rdy handshake, checks result parity, and returns each result with status on a valid/ready output stream.
- Keeps saturating event counters for observability.

Parameters:
- TIMEOUT_CYC, 64: max cycles waited for ack, and separately for result_rdy, before the transaction is abandoned.
- CNT_W, 16: width of the status counters.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  issuer can accept an operand pair.
- in_a  in  16  signed operand A.
- in_b  in  16  signed operand B.
- in_inj_a  in  1  invert arg_a_parity for this transaction.
- in_inj_b  in  1  invert arg_b_parity for this transaction.
- req  out  1  multiplier request.
- arg_a  out  16  signed operand A to the multiplier.
- arg_a_parity  out  1  parity of arg_a.
- arg_b  out  16  signed operand B to the multiplier.
- arg_b_parity  out  1  parity of arg_b.
- ack  in  1  multiplier accepted the operands.
- result  in  32  signed product.
- result_parity  in  1  parity of result.
- arg_parity_error  in  1  multiplier detected an argument parity error.
- result_rdy  in  1  result, result_parity and arg_parity_error valid.
- out_valid  out  1  response valid.
- out_ready  in  1  consumer accepts the response.
- out_result  out  32  captured product; 0 on timeout.
- out_res_par_ok  out  1  result_parity == ^result.
- out_arg_err  out  1  captured arg_parity_error.
- out_timeout  out  1  transaction abandoned.
- cnt_ops  out  CNT_W  completed responses.
- cnt_arg_err  out  CNT_W  responses with out_arg_err=1.
- cnt_par_err  out  CNT_W  responses with out_res_par_ok=0 and no timeout.
- cnt_timeout  out  CNT_W  timed-out responses.

Behaviour:
- All outputs are registered, except in_ready, which is a decode of state == IDLE.
- Reset: state IDLE; req=0; arg_a/arg_b/parities=0; out_valid=0; out_result=0; out_res_par_ok=0; out_arg_err=0; out_timeout=0; all counters=0; timer=0.
- Reset asserted mid-transaction drops req on the next edge with no response; the multiplier is expected to be reset alongside.
- Parity is even-completion: arg_x_parity = ^arg_x XOR in_inj_x.
- FSM state IDLE: in_ready=1. When in_valid is high, register the operands and parities, set req=1, clear timer, go to REQ. The first req=1 cycle is the cycle after the in_valid handshake.
- FSM state REQ: arg_* are held stable.
  - If ack=1: req<=0, clear timer, go to WAIT_RES.
  - If ack and result_rdy are both 1 in the same cycle: capture the result as below and go straight to RESP.
  - If timer reaches TIMEOUT_CYC-1 with no ack: req<=0, out_timeout<=1, out_result<=0, go to RESP.
- FSM state WAIT_RES:
  - On result_rdy=1: out_result<=result, out_res_par_ok<=(result_parity == ^result), out_arg_err<=arg_parity_error, out_timeout<=0, go to RESP.
  - On timer expiry: timeout response as in REQ.
- FSM state RESP: out_valid=1, and outputs are held stable while out_ready=0. When out_ready=1: out_valid<=0, update counters, go to IDLE.
- in_ready is 0 outside IDLE, so at most one transaction is outstanding.
- Timer counts from 0 in REQ and in WAIT_RES; expiry fires on the TIMEOUT_CYC-th waiting cycle.
- ack or result_rdy arriving while in IDLE or RESP is ignored.
- Counters: each increments by 1 per completed response when its condition holds, and saturates at all-ones (no wrap).
- Latency: a back-to-back, always-ready path takes 4 cycles minimum from in handshake to out_valid, with ack and result_rdy each arriving the cycle after being awaited.

Decomposition:
- mult_pkg holds:
  - typedef enum issuer_state_t {IDLE, REQ, WAIT_RES, RESP};
  - typedefs operand_t (signed 16) and product_t (signed 32);
  - function parity_f returning the reduction-XOR.
- Natural sub-module: sat_counter (CNT_W, inc, value), instantiated 4 times.

Test Plan:
- a=3, b=-4 (16'hFFFC), no injection → arg parities 0/0, req high until ack. The multiplier returns 32'hFFFF_FFF4 with result_parity=1, giving out_result=-12, out_res_par_ok=1, out_arg_err=0, cnt_ops=1.
- a=16'h0001, in_inj_a=1 → arg_a_parity=0. The multiplier asserts arg_parity_error, giving out_arg_err=1 and cnt_arg_err=1.
- Multiplier returns result_parity inverted → out_res_par_ok=0 and cnt_par_err=1.
- ack never asserted, TIMEOUT_CYC=8 → req drops after 8 REQ cycles, then out_valid with out_timeout=1, out_result=0, cnt_timeout=1.
- out_ready held 0 for 5 cycles → response outputs stable and in_ready=0. Second operand pair is accepted only after out_ready=1.
- rst pulsed in WAIT_RES → next cycle req=0, out_valid=0, counters 0, in_ready=1.
